// File: rtl/regfile.sv
// 32x32 MIPS register file with hardwired $0, optional write-first
// bypass on both read ports and a bypass-free debug read port.
module regfile #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  DstReg,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  output logic [31:0] out1,
  output logic [31:0] out2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] mem [32];
  logic        wr_en;
  logic        byp_ok;
  logic        byp1;
  logic        byp2;
  logic [31:0] st1;
  logic [31:0] st2;

  assign wr_en = RegWrite && (DstReg != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[DstReg] <= WriteData;
    end
  end

  // $0 is forced here so it reads zero regardless of storage contents
  assign st1      = (rs == 5'd0) ? '0 : mem[rs];
  assign st2      = (rt == 5'd0) ? '0 : mem[rt];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

  assign byp_ok = BYPASS && rst_n && wr_en;
  assign byp1   = byp_ok && (DstReg == rs);
  assign byp2   = byp_ok && (DstReg == rt);

  assign out1 = byp1 ? WriteData : st1;
  assign out2 = byp2 ? WriteData : st2;

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: both bypass settings side by side, directed
// vectors, reset corner cases and random traffic vs an array model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, dst, dbg;
  logic [31:0] wd;
  logic        we;
  logic [31:0] o1, o2, dd;
  logic [31:0] n1, n2, nd;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [32];

  typedef struct {
    logic        we;
    logic [4:0]  dst;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
  } vec_t;

  vec_t tbl [$];

  regfile #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt),
    .DstReg(dst), .WriteData(wd), .RegWrite(we),
    .out1(o1), .out2(o2), .dbg_addr(dbg), .dbg_data(dd)
  );

  regfile #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt),
    .DstReg(dst), .WriteData(wd), .RegWrite(we),
    .out1(n1), .out2(n2), .dbg_addr(dbg), .dbg_data(nd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] stored(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : ref_mem[a];
  endfunction

  function automatic logic [31:0] expect_rd(input logic [4:0] a,
                                            input bit byp);
    if (byp && rst_n && we && dst != 5'd0 && dst == a) return wd;
    return stored(a);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    end else if (we && dst != 5'd0) begin
      ref_mem[dst] = wd;
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    rst_n = 1'b0;
    we = 1'b0; dst = '0; wd = '0; rs = '0; rt = '0; dbg = '0;

    // reset state
    rs = 5'd7; rt = 5'd12; dbg = 5'd31;
    #2;
    chk("rst_out1", o1, 32'h0);
    chk("rst_out2", o2, 32'h0);
    chk("rst_dbg", dd, 32'h0);
    chk("rst_nb_out1", n1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // full sweep
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; dst = 5'(i); wd = 32'h100 + i;
      edge_step();
    end
    we = 1'b0; wd = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(i); dbg = 5'(i);
      #1;
      chk($sformatf("sweep_out1_%0d", i), o1,
          (i == 0) ? 32'h0 : 32'h100 + i);
      chk($sformatf("sweep_out2_%0d", i), o2,
          (i == 0) ? 32'h0 : 32'h100 + i);
      chk($sformatf("sweep_dbg_%0d", i), dd,
          (i == 0) ? 32'h0 : 32'h100 + i);
    end
    @(negedge clk);

    // directed vectors, each checked before its edge
    tbl.push_back('{1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd8,
                    32'h1234_5678, 32'h1234_5678, 32'h108, 32'h108});
    tbl.push_back('{1'b0, 5'd8, 32'hFFFF_FFFF, 5'd8, 5'd8,
                    32'h1234_5678, 32'h1234_5678,
                    32'h1234_5678, 32'h1234_5678});
    tbl.push_back('{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0,
                    32'h0, 32'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 5'd3, 32'h11, 5'd3, 5'd3,
                    32'h11, 32'h11, 32'h103, 32'h103});
    tbl.push_back('{1'b1, 5'd4, 32'h44, 5'd4, 5'd3,
                    32'h44, 32'h11, 32'h104, 32'h11});
    tbl.push_back('{1'b1, 5'd3, 32'h22, 5'd3, 5'd4,
                    32'h22, 32'h44, 32'h11, 32'h44});
    tbl.push_back('{1'b0, 5'd3, 32'h0, 5'd3, 5'd4,
                    32'h22, 32'h44, 32'h22, 32'h44});
    tbl.push_back('{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd9, 5'd5,
                    32'h109, 32'hDEAD_BEEF, 32'h109, 32'h105});
    tbl.push_back('{1'b0, 5'bx, 32'hx, 5'd5, 5'd6,
                    32'hDEAD_BEEF, 32'h106, 32'hDEAD_BEEF, 32'h106});
    tbl.push_back('{1'b1, 5'd3, 32'h33, 5'd3, 5'd3,
                    32'h33, 32'h33, 32'h22, 32'h22});
    foreach (tbl[k]) begin
      we = tbl[k].we; dst = tbl[k].dst; wd = tbl[k].wd;
      rs = tbl[k].rs; rt = tbl[k].rt; dbg = tbl[k].rt;
      #1;
      chk($sformatf("vec%0d_out1", k), o1, tbl[k].e1);
      chk($sformatf("vec%0d_out2", k), o2, tbl[k].e2);
      chk($sformatf("vec%0d_nb_out1", k), n1, tbl[k].n1);
      chk($sformatf("vec%0d_nb_out2", k), n2, tbl[k].n2);
      chk($sformatf("vec%0d_dbg", k), dd, tbl[k].n2);
      edge_step();
    end

    // $0 after an attempted write, and $5 after its write
    we = 1'b0; rs = 5'd0; rt = 5'd5; dbg = 5'd0;
    #1;
    chk("zero_out1_after", o1, 32'h0);
    chk("zero_dbg_after", dd, 32'h0);
    chk("r5_out2", o2, 32'hDEAD_BEEF);

    // asynchronous clear mid-cycle, no clock edge
    @(posedge clk);
    #2;
    rs = 5'd5; rt = 5'd5; dbg = 5'd5;
    rst_n = 1'b0;
    #1;
    chk("aclr_dbg5", dd, 32'h0);
    chk("aclr_out1", o1, 32'h0);
    chk("aclr_out2", o2, 32'h0);
    chk("aclr_nb_dbg5", nd, 32'h0);
    model_edge();

    // enabled write held in reset across an edge
    we = 1'b1; dst = 5'd9; wd = 32'hA5A5_A5A5;
    rs = 5'd9; rt = 5'd9; dbg = 5'd9;
    #1;
    chk("rstwr_pre_out1", o1, 32'h0);
    chk("rstwr_pre_out2", o2, 32'h0);
    @(posedge clk);
    model_edge();
    #1;
    chk("rstwr_post_out1", o1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    #1;
    chk("rstwr_rel_dbg9", dd, 32'h0);
    chk("rstwr_rel_out1", o1, 32'h0);

    // first edge after release writes normally
    @(negedge clk);
    we = 1'b1; dst = 5'd7; wd = 32'h77; dbg = 5'd7;
    edge_step();
    we = 1'b0;
    #1;
    chk("release_first_write", dd, 32'h77);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(0, 3) != 0);
      dst = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      dbg = ($urandom_range(0, 1) == 0) ? dst : 5'($urandom_range(0, 31));
      #1;
      chk("rnd_out1", o1, expect_rd(rs, 1'b1));
      chk("rnd_out2", o2, expect_rd(rt, 1'b1));
      chk("rnd_dbg", dd, stored(dbg));
      chk("rnd_nb_out1", n1, expect_rd(rs, 1'b0));
      chk("rnd_nb_out2", n2, expect_rd(rt, 1'b0));
      edge_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the single-cycle MIPS datapath, sitting between instruction decode and execute. It supplies two source operands: `out1` feeds the ALU A input, and `out2` feeds the ALUSrc mux and the data-memory write data. It accepts one write-back per cycle, using the register selected by the RegDst mux and the data selected by the MemtoReg mux. It holds 32 x 32-bit registers; `$0` is hardwired to zero.

## Interface
- `BYPASS`, default 1: 1 = a read of the register being written in the same cycle returns `WriteData` (write-first); 0 = the read returns the stored value until the clock edge.
- `clk` input 1: rising-edge clock for all register updates.
- `rst_n` input 1: reset, asynchronous, active-low; clears all registers.
- `rs` input 5: read address 1 (instr[25:21]).
- `rt` input 5: read address 2 (instr[20:16]).
- `DstReg` input 5: write address from the RegDst mux.
- `WriteData` input 32: write data from the MemtoReg mux.
- `RegWrite` input 1: write enable from control.
- `out1` output 32: contents of register `rs`.
- `out2` output 32: contents of register `rt`.
- `dbg_addr` input 5: debug/testbench read address.
- `dbg_data` output 32: contents of register `dbg_addr`; bypass never applies.

## Operation
- Storage: 32 entries x 32 bits. Entry 0 is never written and always reads 0, whatever `RegWrite`, `DstReg` or `WriteData` are.
- Write:
  - Occurs on the rising edge of `clk` when `rst_n`=1, `RegWrite`=1 and `DstReg`!=0.
  - The entry `DstReg` takes `WriteData`.
  - Every other entry holds its value.
  - `RegWrite`=0 means no entry changes.
- Read: `out1`, `out2` and `dbg_data` are combinational functions of the address, the stored contents and, when BYPASS=1, the pending write.
- Bypass (BYPASS=1 only), for each of `out1`/`out2` independently:
  - Condition: `rst_n`=1, `RegWrite`=1, `DstReg`!=0 and `DstReg` equal to that port's address.
  - Result: the port shows `WriteData`; otherwise it shows the stored entry.
  - When `rs`==`rt`==`DstReg`, both ports bypass.
  - Bypass to address 0 never happens; a 0 address reads 0.
- Reset:
  - `rst_n` falling clears all 32 entries to 0 immediately, with no clock required.
  - While `rst_n`=0, all clock edges are ignored and bypass is suppressed.
  - Resulting outputs: `out1`=`out2`=`dbg_data`=0.
- Reset mid-write: if `rst_n` drops in the same cycle as an enabled write, the write is lost. After release, the target entry reads 0.
- Reset release: the first rising edge with `rst_n`=1 is a normal write edge.
- X handling: with `RegWrite`=0, X on `DstReg`/`WriteData` must not corrupt any entry.

## Timing
- Write latency: 1 clock. Data is visible in storage (and on non-bypassed ports) after the rising edge where the write was enabled.
- Read latency: 0 cycles (combinational). The path from `rs`/`rt` to `out1`/`out2` is a 32:1 mux, plus a 2:1 bypass mux when BYPASS=1.
- Bypass path: `WriteData` to `out1`/`out2` is combinational within the same cycle. Together with the upstream mux3 path, it sets the single-cycle critical path, and the integration timing budget accounts for it.
- Reset: the asynchronous assertion affects outputs within the same delta/propagation time. Deassertion is expected synchronous to `clk` externally; no internal synchronizer is provided.
- Outputs after reset: 0 on all outputs until the first write.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to $5, then pulse `rst_n` low mid-cycle with no clock edge.
  - Response: `dbg_data`($5)=0 immediately; `out1`=`out2`=0.
- Basic write/read:
  - Stimulus: RegWrite=1, DstReg=8, WriteData=0x12345678, one edge, then rs=8, rt=8.
  - Response: `out1`=`out2`=0x12345678.
  - Then with RegWrite=0 and WriteData=0xFFFFFFFF, one edge: $8 is unchanged.
- $0 protection:
  - Stimulus: RegWrite=1, DstReg=0, WriteData=0xFFFFFFFF, rs=0.
  - Response: `out1`=0 both before and after the edge; `dbg_data`($0)=0.
- Bypass (BYPASS=1):
  - Setup: $3=0x00000011.
  - Stimulus: RegWrite=1, DstReg=3, WriteData=0x00000022, rs=3, rt=4 ($4=0x44).
  - Response before the edge: `out1`=0x22, `out2`=0x44.
  - Repeat with BYPASS=0: `out1`=0x11 before the edge and 0x22 after it.
- Reset during write:
  - Stimulus: RegWrite=1, DstReg=9, WriteData=0xA5A5A5A5, with `rst_n` low across the rising edge, then release.
  - Response: $9=0; `out1`(rs=9)=0 while in reset, including with bypass conditions met.
- Full sweep:
  - Stimulus: write value 0x100+i to $i for i=1..31 on consecutive edges.
  - Response: reading back through `out1`, `out2` and `dbg_data` returns 0x100+i for every i, and $0 reads 0.
